// File: rtl/rv32imf_irq_pkg.sv
// Shared constants and types for the rv32imf interrupt aggregator.
package rv32imf_irq_pkg;

    localparam logic [4:0] REG_PENDING = 5'h00;
    localparam logic [4:0] REG_ENABLE  = 5'h04;
    localparam logic [4:0] REG_EDGE    = 5'h08;
    localparam logic [4:0] REG_MSIP    = 5'h0C;
    localparam logic [4:0] REG_LAST_ID = 5'h10;

    localparam int FAST_IRQ_BASE = 16;
    localparam int MSIP_IRQ      = 3;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
    } cfg_req_t;

    typedef enum logic {
        CFG_IDLE,
        CFG_RESP
    } cfg_state_e;

endpackage

// File: rtl/rv32imf_irq_if.sv
// Software register port: request/grant with a fixed one-cycle response.
interface rv32imf_irq_if;

    logic        req;
    logic        gnt;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/rv32imf_irq_sync.sv
// Multi-stage flop synchronizer for the asynchronous interrupt sources.
module rv32imf_irq_sync #(
    parameter int NUM_SRC     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] async_i,
    output logic [NUM_SRC-1:0] sync_o
);

    logic [SYNC_STAGES-1:0][NUM_SRC-1:0] stage_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[SYNC_STAGES-2:0], async_i};
        end
    end

    assign sync_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/rv32imf_irq_ctrl.sv
// Interrupt aggregator: synchronised sources, edge/level pending, ack handling and register port.
module rv32imf_irq_ctrl
    import rv32imf_irq_pkg::*;
#(
    parameter int NUM_SRC     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] src_i,
    output logic [31:0]        irq_o,
    input  logic               irq_ack_i,
    input  logic [4:0]         irq_id_i,
    rv32imf_irq_if.slave       cfg
);

    cfg_req_t     cfgReq;
    logic [4:0]   wordAddr;
    logic         wrEn;
    logic         rdEn;
    logic [NUM_SRC-1:0] srcSync, riseDet, ackHit, ackClr, w1cClr;
    logic [NUM_SRC-1:0] srcDly_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] edge_q, edge_d;
    logic         msip_q, msip_d;
    logic [4:0]   lastId_q, lastId_d;
    logic [31:0]  rdMux, rdata_q, rdata_d;
    cfg_state_e   state_q, state_d;
    logic         unusedBits;

    assign cfgReq     = '{we: cfg.we, addr: cfg.addr, wdata: cfg.wdata};
    assign wordAddr   = {cfgReq.addr[4:2], 2'b00};
    assign wrEn       = cfg.req & cfgReq.we;
    assign rdEn       = cfg.req & ~cfgReq.we;
    assign cfg.gnt    = cfg.req;
    assign unusedBits = ^{cfgReq.wdata, cfgReq.addr[1:0]};

    rv32imf_irq_sync #(
        .NUM_SRC    (NUM_SRC),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .async_i(src_i),
        .sync_o (srcSync)
    );

    // A fresh rising edge outranks ack/W1C clears; level bits simply track the synchronised input.
    always_comb begin
        riseDet = srcSync & ~srcDly_q;
        ackHit  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            ackHit[k] = irq_ack_i && (irq_id_i == 5'(FAST_IRQ_BASE + k));
        end
        ackClr    = ackHit & edge_q;
        w1cClr    = (wrEn && wordAddr == REG_PENDING) ? (cfgReq.wdata[NUM_SRC-1:0] & edge_q) : '0;
        pending_d = (edge_q & (riseDet | (pending_q & ~(ackClr | w1cClr)))) | (~edge_q & srcSync);
        enable_d  = (wrEn && wordAddr == REG_ENABLE) ? cfgReq.wdata[NUM_SRC-1:0] : enable_q;
        edge_d    = (wrEn && wordAddr == REG_EDGE)   ? cfgReq.wdata[NUM_SRC-1:0] : edge_q;
        msip_d    = (wrEn && wordAddr == REG_MSIP)   ? cfgReq.wdata[0] : msip_q;
        lastId_d  = irq_ack_i ? irq_id_i : lastId_q;
    end

    always_comb begin
        rdMux = '0;
        case (wordAddr)
            REG_PENDING: rdMux = 32'(pending_q);
            REG_ENABLE:  rdMux = 32'(enable_q);
            REG_EDGE:    rdMux = 32'(edge_q);
            REG_MSIP:    rdMux = {31'b0, msip_q};
            REG_LAST_ID: rdMux = {27'b0, lastId_q};
            default:     rdMux = '0;
        endcase
        rdata_d = rdEn ? rdMux : '0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CFG_IDLE: state_d = cfg.req ? CFG_RESP : CFG_IDLE;
            CFG_RESP: state_d = cfg.req ? CFG_RESP : CFG_IDLE;
            default:  state_d = CFG_IDLE;
        endcase
    end

    always_comb begin
        cfg.rvalid = (state_q == CFG_RESP);
        cfg.rdata  = rdata_q;
    end

    always_comb begin
        irq_o                            = '0;
        irq_o[MSIP_IRQ]                  = msip_q;
        irq_o[FAST_IRQ_BASE +: NUM_SRC]  = pending_q & enable_q;
    end

    // Clearing srcDly_q on reset makes a source already high at release look like a rising edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            srcDly_q  <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            edge_q    <= '0;
            msip_q    <= 1'b0;
            lastId_q  <= '0;
            rdata_q   <= '0;
            state_q   <= CFG_IDLE;
        end else begin
            srcDly_q  <= srcSync;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            edge_q    <= edge_d;
            msip_q    <= msip_d;
            lastId_q  <= lastId_d;
            rdata_q   <= rdata_d;
            state_q   <= state_d;
        end
    end

endmodule

// File: tb/tb_rv32imf_irq_ctrl.sv
// Directed self-checking bench for the interrupt aggregator.
module tb_rv32imf_irq_ctrl;
    import rv32imf_irq_pkg::*;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic [15:0] src   = '0;
    logic [31:0] irq;
    logic        ack   = 1'b0;
    logic [4:0]  ackId = '0;
    logic [31:0] rd;
    int          testsRun    = 0;
    int          testsFailed = 0;

    rv32imf_irq_if cfgBus();

    rv32imf_irq_ctrl #(
        .NUM_SRC    (16),
        .SYNC_STAGES(2)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .src_i    (src),
        .irq_o    (irq),
        .irq_ack_i(ack),
        .irq_id_i (ackId),
        .cfg      (cfgBus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] value, input int cycles);
        src = value;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic cfgWrite(input logic [4:0] addr, input logic [31:0] data);
        cfgBus.req   = 1'b1;
        cfgBus.we    = 1'b1;
        cfgBus.addr  = addr;
        cfgBus.wdata = data;
        #1;
        checkOutput("wr gnt", 32'(cfgBus.gnt), 32'd1);
        @(negedge clk);
        cfgBus.req = 1'b0;
        cfgBus.we  = 1'b0;
        checkOutput("wr rvalid", 32'(cfgBus.rvalid), 32'd1);
        checkOutput("wr rdata", cfgBus.rdata, 32'd0);
    endtask

    task automatic cfgRead(input logic [4:0] addr, output logic [31:0] data);
        cfgBus.req  = 1'b1;
        cfgBus.we   = 1'b0;
        cfgBus.addr = addr;
        @(negedge clk);
        cfgBus.req = 1'b0;
        checkOutput("rd rvalid", 32'(cfgBus.rvalid), 32'd1);
        data = cfgBus.rdata;
    endtask

    task automatic ackPulse(input logic [4:0] id);
        ack   = 1'b1;
        ackId = id;
        @(negedge clk);
        ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cfgBus.req   = 1'b0;
        cfgBus.we    = 1'b0;
        cfgBus.addr  = '0;
        cfgBus.wdata = '0;

        repeat (2) @(negedge clk);
        checkOutput("reset irq", irq, 32'h0);
        checkOutput("reset rvalid", 32'(cfgBus.rvalid), 32'd0);
        rst = 1'b0;

        // Edge path on bit0
        cfgWrite(REG_EDGE, 32'h1);
        cfgWrite(REG_ENABLE, 32'h1);
        applyStimulus(16'h0001, 1);
        applyStimulus(16'h0000, 1);
        checkOutput("edge before latency", irq, 32'h0);
        @(negedge clk);
        checkOutput("edge after latency", irq, 32'h0001_0000);
        ackPulse(5'd16);
        checkOutput("edge ack clears", irq, 32'h0);
        cfgRead(REG_LAST_ID, rd);
        checkOutput("last id 16", rd, 32'd16);

        // Level path on bit2
        cfgWrite(REG_ENABLE, 32'h5);
        applyStimulus(16'h0004, 3);
        checkOutput("level set", irq, 32'h0004_0000);
        ackPulse(5'd18);
        checkOutput("level ack keeps", irq, 32'h0004_0000);
        applyStimulus(16'h0000, 2);
        checkOutput("level drop 2 cycles", irq, 32'h0004_0000);
        @(negedge clk);
        checkOutput("level drop 3 cycles", irq, 32'h0);

        // Collision on bit1
        cfgWrite(REG_EDGE, 32'h3);
        cfgWrite(REG_ENABLE, 32'h7);
        applyStimulus(16'h0002, 1);
        applyStimulus(16'h0000, 2);
        checkOutput("bit1 pending", irq, 32'h0002_0000);
        applyStimulus(16'h0002, 1);
        applyStimulus(16'h0000, 1);
        ackPulse(5'd17);
        checkOutput("edge beats ack", irq, 32'h0002_0000);
        @(negedge clk);
        checkOutput("bit1 held", irq, 32'h0002_0000);
        applyStimulus(16'h0002, 1);
        applyStimulus(16'h0000, 1);
        ack   = 1'b1;
        ackId = 5'd17;
        cfgWrite(REG_PENDING, 32'h2);
        ack = 1'b0;
        checkOutput("edge beats ack+w1c", irq, 32'h0002_0000);
        ackPulse(5'd17);
        checkOutput("bit1 ack clears", irq, 32'h0);

        // Mask on bit5
        cfgWrite(REG_EDGE, 32'h23);
        cfgWrite(REG_ENABLE, 32'h0);
        applyStimulus(16'h0020, 1);
        applyStimulus(16'h0000, 2);
        checkOutput("masked irq", irq, 32'h0);
        cfgRead(REG_PENDING, rd);
        checkOutput("pending bit5", rd, 32'h20);
        cfgWrite(REG_ENABLE, 32'h20);
        checkOutput("unmasked irq", irq, 32'h0020_0000);
        cfgWrite(REG_PENDING, 32'h20);
        checkOutput("w1c clears", irq, 32'h0);

        // MSIP and register port
        cfgWrite(REG_MSIP, 32'h1);
        checkOutput("msip set", irq, 32'h8);
        cfgRead(REG_MSIP, rd);
        checkOutput("msip read", rd, 32'h1);
        cfgRead(5'h1C, rd);
        checkOutput("unmapped read", rd, 32'h0);
        cfgRead(REG_EDGE, rd);
        checkOutput("edge read", rd, 32'h23);
        cfgWrite(REG_MSIP, 32'h0);
        checkOutput("msip clear", irq, 32'h0);

        // Reset mid-operation with a read outstanding
        cfgWrite(REG_ENABLE, 32'h21);
        cfgWrite(REG_MSIP, 32'h1);
        applyStimulus(16'h0001, 1);
        applyStimulus(16'h0000, 2);
        checkOutput("pre-reset irq", irq, 32'h0001_0008);
        cfgBus.req  = 1'b1;
        cfgBus.we   = 1'b0;
        cfgBus.addr = REG_PENDING;
        rst         = 1'b1;
        @(negedge clk);
        cfgBus.req = 1'b0;
        rst        = 1'b0;
        checkOutput("mid reset irq", irq, 32'h0);
        checkOutput("mid reset rvalid", 32'(cfgBus.rvalid), 32'd0);
        @(negedge clk);
        checkOutput("dropped rvalid", 32'(cfgBus.rvalid), 32'd0);
        cfgRead(REG_PENDING, rd);
        checkOutput("post reset pending", rd, 32'h0);
        cfgRead(REG_ENABLE, rd);
        checkOutput("post reset enable", rd, 32'h0);
        cfgRead(REG_EDGE, rd);
        checkOutput("post reset edge", rd, 32'h0);
        cfgRead(REG_MSIP, rd);
        checkOutput("post reset msip", rd, 32'h0);
        cfgRead(REG_LAST_ID, rd);
        checkOutput("post reset last id", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
